// File: rtl/note_lane_scroller.sv
// One guitar lane: spawns notes, scrolls them down each frame, and resolves hits/misses at the strike line.
// Optional consecutive-hit counter is built when NOTE_STREAK_EN is defined; otherwise streak is tied to 0.
module note_lane_scroller #(
  parameter int SLOTS      = 4,
  parameter int LANE_X     = 100,
  parameter int NOTE_WIDTH = 40,
  parameter int SPEED      = 4,
  parameter int STRIKE_Y   = 400,
  parameter int WINDOW     = 20
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic                     spawn_valid,
  output logic                     spawn_ready,
  input  logic                     press,
  input  logic [$clog2(SLOTS)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [9:0]               note_x,
  output logic [31:0]              note_y,
  output logic [6:0]               note_width,
  output logic                     hit_pulse,
  output logic                     miss_pulse,
  output logic [7:0]               streak
);

  localparam int IW = $clog2(SLOTS);
  localparam int CW = IW + 1;
  localparam logic [31:0] WIN_LO = 32'(STRIKE_Y - WINDOW);
  localparam logic [31:0] WIN_HI = 32'(STRIKE_Y + WINDOW);

  logic [31:0]   r_y [SLOTS];
  logic [IW-1:0] r_head;
  logic [IW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_hit;
  logic          r_miss;

  logic [31:0]    w_head_y;
  logic           w_live;
  logic           w_in_win;
  logic           w_passed;
  logic           w_hit;
  logic           w_bad;
  logic           w_pop;
  logic           w_spawn;
  logic [SLOTS-1:0] w_live_mask;
  logic [IW-1:0]  w_rd_slot;

  assign w_head_y    = r_y[r_head];
  assign w_live      = (r_count != '0);
  assign w_in_win    = (w_head_y >= WIN_LO) && (w_head_y <= WIN_HI);
  assign w_passed    = w_live && (w_head_y > WIN_HI);
  assign w_hit       = press && w_live && w_in_win;
  assign w_bad       = press && !(w_live && w_in_win);
  assign w_pop       = w_hit || w_passed;
  assign spawn_ready = (r_count < CW'(SLOTS));
  assign w_spawn     = spawn_valid && spawn_ready;

  // A slot is live when its distance from head (mod SLOTS) is below count.
  always_comb begin
    w_live_mask = '0;
    for (int i = 0; i < SLOTS; i++) begin
      w_live_mask[i] = ({1'b0, IW'(i) - r_head} < r_count);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      if (w_pop)   r_head <= r_head + 1'b1;
      if (w_spawn) r_tail <= r_tail + 1'b1;
      r_count <= r_count + CW'(w_spawn) - CW'(w_pop);
      r_hit   <= w_hit;
      r_miss  <= w_bad || w_passed;
    end
  end

  // Position storage carries no reset; dead slots are rewritten to 0 on spawn.
  always_ff @(posedge clock) begin
    for (int i = 0; i < SLOTS; i++) begin
      if (w_spawn && (IW'(i) == r_tail)) begin
        r_y[i] <= '0;
      end else if (frame_tick && w_live_mask[i]) begin
        r_y[i] <= r_y[i] + 32'(SPEED);
      end
    end
  end

  assign w_rd_slot  = r_head + rd_idx;
  assign rd_valid   = ({1'b0, rd_idx} < r_count);
  assign note_x     = rd_valid ? 10'(LANE_X) : '0;
  assign note_y     = rd_valid ? r_y[w_rd_slot] : '0;
  assign note_width = 7'(NOTE_WIDTH);
  assign hit_pulse  = r_hit;
  assign miss_pulse = r_miss;

`ifdef NOTE_STREAK_EN
  logic [7:0] r_streak;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      r_streak <= '0;
    end else if (w_hit) begin
      r_streak <= sat_inc8(r_streak);
    end else if (w_bad || w_passed) begin
      r_streak <= '0;
    end
  end

  assign streak = r_streak;
`else
  assign streak = '0;
`endif

endmodule

// File: tb/tb_note_lane_scroller.sv
// Directed table-driven bench for note_lane_scroller (default parameters, SLOTS=4).
module tb_note_lane_scroller;

`ifdef NOTE_STREAK_EN
  localparam bit STREAK_ON = 1'b1;
`else
  localparam bit STREAK_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic        spawn_valid = 1'b0;
  logic        spawn_ready;
  logic        press = 1'b0;
  logic [1:0]  rd_idx = '0;
  logic        rd_valid;
  logic [9:0]  note_x;
  logic [31:0] note_y;
  logic [6:0]  note_width;
  logic        hit_pulse;
  logic        miss_pulse;
  logic [7:0]  streak;

  int n_vec = 0;
  int n_bad = 0;

  note_lane_scroller dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .press(press),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .note_x(note_x), .note_y(note_y),
    .note_width(note_width), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .streak(streak)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          reps;
    bit          rst, tick, spawn, prs;
    logic [1:0]  idx;
    bit          e_rdy, e_vld;
    logic [31:0] e_y;
    bit          e_hit, e_miss;
    logic [7:0]  e_strk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int reps, input bit rst, input bit tick, input bit spawn,
                     input bit prs, input logic [1:0] idx, input bit e_rdy, input bit e_vld,
                     input logic [31:0] e_y, input bit e_hit, input bit e_miss,
                     input logic [7:0] e_strk);
    vec_t v;
    v.reps = reps; v.rst = rst; v.tick = tick; v.spawn = spawn; v.prs = prs; v.idx = idx;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_y = e_y; v.e_hit = e_hit; v.e_miss = e_miss;
    v.e_strk = e_strk;
    vecs.push_back(v);
  endtask

  task automatic chk(input string tag, input bit e_rdy, input bit e_vld, input logic [31:0] e_y,
                     input bit e_hit, input bit e_miss, input logic [7:0] e_strk_on);
    logic [7:0] e_strk;
    logic [9:0] e_x;
    e_strk = STREAK_ON ? e_strk_on : 8'd0;
    e_x    = e_vld ? 10'd100 : 10'd0;
    n_vec++;
    if (spawn_ready !== e_rdy) begin n_bad++; $display("FAIL %s spawn_ready got %0b want %0b", tag, spawn_ready, e_rdy); end
    if (rd_valid !== e_vld) begin n_bad++; $display("FAIL %s rd_valid got %0b want %0b", tag, rd_valid, e_vld); end
    if (note_x !== e_x) begin n_bad++; $display("FAIL %s note_x got %0d want %0d", tag, note_x, e_x); end
    if (note_y !== (e_vld ? e_y : 32'd0)) begin n_bad++; $display("FAIL %s note_y got %0d want %0d", tag, note_y, e_y); end
    if (note_width !== 7'd40) begin n_bad++; $display("FAIL %s note_width got %0d want 40", tag, note_width); end
    if (hit_pulse !== e_hit) begin n_bad++; $display("FAIL %s hit_pulse got %0b want %0b", tag, hit_pulse, e_hit); end
    if (miss_pulse !== e_miss) begin n_bad++; $display("FAIL %s miss_pulse got %0b want %0b", tag, miss_pulse, e_miss); end
    if (streak !== e_strk) begin n_bad++; $display("FAIL %s streak got %0d want %0d", tag, streak, e_strk); end
  endtask

  initial begin
    //   reps rst tk sp pr idx  rdy vld y    hit miss strk
    add(2,   1, 0, 0, 0, 0,   1,  0,  0,   0,  0,   0);   // reset state
    // single note scrolled to strike line, then hit
    add(1,   0, 0, 1, 0, 0,   1,  1,  0,   0,  0,   0);
    add(100, 0, 1, 0, 0, 0,   1,  1,  400, 0,  0,   0);
    add(1,   0, 0, 0, 1, 0,   1,  0,  0,   1,  0,   1);
    add(1,   0, 0, 0, 0, 0,   1,  0,  0,   0,  0,   1);
    // note scrolls past the window: one miss
    add(1,   0, 0, 1, 0, 0,   1,  1,  0,   0,  0,   1);
    add(105, 0, 1, 0, 0, 0,   1,  1,  420, 0,  0,   1);
    add(1,   0, 1, 0, 0, 0,   1,  1,  424, 0,  0,   1);
    add(1,   0, 0, 0, 0, 0,   1,  0,  0,   0,  1,   0);
    add(1,   0, 0, 0, 0, 0,   1,  0,  0,   0,  0,   0);
    // early press misses and keeps note, later press hits
    add(1,   0, 0, 1, 0, 0,   1,  1,  0,   0,  0,   0);
    add(94,  0, 1, 0, 0, 0,   1,  1,  376, 0,  0,   0);
    add(1,   0, 0, 0, 1, 0,   1,  1,  376, 0,  1,   0);
    add(2,   0, 1, 0, 0, 0,   1,  1,  384, 0,  0,   0);
    add(1,   0, 0, 0, 1, 0,   1,  0,  0,   1,  0,   1);
    add(1,   0, 0, 0, 0, 0,   1,  0,  0,   0,  0,   1);
    // fill all slots
    add(6,   0, 0, 1, 0, 0,   0,  1,  0,   0,  0,   1);
    add(0,   0, 0, 0, 0, 1,   0,  1,  0,   0,  0,   1);
    add(0,   0, 0, 0, 0, 2,   0,  1,  0,   0,  0,   1);
    add(0,   0, 0, 0, 0, 3,   0,  1,  0,   0,  0,   1);
    add(100, 0, 1, 0, 0, 0,   0,  1,  400, 0,  0,   1);
    // pop at full while spawning: spawn refused
    add(1,   0, 0, 1, 1, 3,   1,  0,  0,   1,  0,   2);
    add(0,   0, 0, 0, 0, 0,   1,  1,  400, 1,  0,   2);
    // spawn wraps tail; new note is youngest
    add(1,   0, 0, 1, 0, 3,   0,  1,  0,   0,  0,   2);
    add(0,   0, 0, 0, 0, 0,   0,  1,  400, 0,  0,   2);
    add(1,   0, 0, 0, 1, 0,   1,  1,  400, 1,  0,   3);
    add(1,   0, 0, 0, 1, 1,   1,  1,  0,   1,  0,   4);
    add(0,   0, 0, 0, 0, 2,   1,  0,  0,   1,  0,   4);
    // reset mid-stream, then press on empty lane
    add(1,   1, 0, 0, 0, 0,   1,  0,  0,   0,  0,   0);
    add(1,   0, 0, 0, 1, 0,   1,  0,  0,   0,  1,   0);
    add(1,   0, 0, 0, 0, 0,   1,  0,  0,   0,  0,   0);

    @(negedge clock);
    foreach (vecs[k]) begin
      reset = vecs[k].rst; frame_tick = vecs[k].tick; spawn_valid = vecs[k].spawn;
      press = vecs[k].prs; rd_idx = vecs[k].idx;
      repeat (vecs[k].reps) @(posedge clock);
      #1;
      chk($sformatf("vec%0d", k), vecs[k].e_rdy, vecs[k].e_vld, vecs[k].e_y,
          vecs[k].e_hit, vecs[k].e_miss, vecs[k].e_strk);
    end

    // Press landing on the same cycle the passed note pops: one miss only.
    reset = 1'b0; frame_tick = 1'b0; press = 1'b0; rd_idx = 2'd0;
    spawn_valid = 1'b1;
    @(posedge clock); #1;
    spawn_valid = 1'b0; frame_tick = 1'b1;
    repeat (106) @(posedge clock);
    #1;
    frame_tick = 1'b0;
    chk("pass_pre", 1'b1, 1'b1, 32'd424, 1'b0, 1'b0, 8'd0);
    press = 1'b1;
    @(posedge clock); #1;
    press = 1'b0;
    chk("pass_press", 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 8'd0);
    @(posedge clock); #1;
    chk("pass_single", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/note_lane_scroller.md
Name: note_lane_scroller

Overview:
- Producer side of the note-geometry interface. Owns the live notes of one guitar lane, moves them down once per video frame, and resolves each note as a hit or a miss at the strike line.
- Exposes each live note as (note_x, note_y, note_width) so the per-pixel bounds checker can draw it.
- One instance per lane. Sits between the chart sequencer (spawn side), the controller input (press side) and the VGA renderer (read side).

Parameters:
- SLOTS, 4, maximum live notes per lane (power of two, ≥2).
- LANE_X, 100, left x of this lane in pixels (10-bit).
- NOTE_WIDTH, 40, note square size in pixels (7-bit).
- SPEED, 4, pixels added to note_y per frame tick.
- STRIKE_Y, 400, y of the strike line.
- WINDOW, 20, hit tolerance in pixels; requires STRIKE_Y ≥ WINDOW.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame, during vblank.
- spawn_valid  in  1  chart requests a new note in this lane.
- spawn_ready  out  1  a slot is free.
- press  in  1  one-cycle strum pulse for this lane.
- rd_idx  in  log2(SLOTS)  render slot select; 0 = oldest note.
- rd_valid  out  1  the selected slot holds a live note.
- note_x  out  10  LANE_X when rd_valid, else 0.
- note_y  out  32  y of the selected note when rd_valid, else 0.
- note_width  out  7  NOTE_WIDTH (constant).
- hit_pulse  out  1  one-cycle pulse on a resolved hit.
- miss_pulse  out  1  one-cycle pulse on a miss (note passed, or bad press).
- streak  out  8  consecutive-hit count (see Optional Feature).

Behaviour:
- Storage: circular buffer of SLOTS 32-bit y registers, with head, tail and count (count width log2(SLOTS)+1). Notes are ordered oldest-first, so only the head note can resolve.
- Reset: count, head and tail = 0; hit_pulse, miss_pulse and streak = 0; spawn_ready = 1; rd_valid = 0.
- Spawn: accepted when spawn_valid && spawn_ready, with spawn_ready = (count < SLOTS). The new slot is written with y = 0 at tail, and tail increments mod SLOTS.
- Advance: on frame_tick, every live slot gets y ← y + SPEED (unsigned). A note spawned in the same cycle stays at 0.
- Hit: on press with count > 0 and head y within [STRIKE_Y−WINDOW, STRIKE_Y+WINDOW], evaluated on pre-tick register values:
  - pop the head;
  - hit_pulse = 1 the next cycle.
- Bad press: press with count = 0, or head outside the window → no pop, miss_pulse = 1 the next cycle.
- Passed note: when head y > STRIKE_Y+WINDOW (checked every cycle on registered y), pop the head and pulse miss_pulse the next cycle. Because a miss pops before y can grow large, y never wraps.
- Simultaneous events:
  - A hit pop and a passed-note pop are mutually exclusive by range.
  - A bad press and a passed-note pop in the same cycle produce a single miss_pulse.
  - Spawn and pop in the same cycle: count unchanged, both pointers move.
  - Spawn at full when a pop occurs in the same cycle is still refused, because spawn_ready is computed from registered count.
- Pulses: hit_pulse and miss_pulse are registered, single-cycle, never high together.
- Read port: combinational. Slot = (head + rd_idx) mod SLOTS; rd_valid = (rd_idx < count).
- Reset mid-operation drops all live notes with no pulses.

Optional Feature:
- Macro: NOTE_STREAK_EN.
- Defined:
  - streak increments on each hit_pulse and saturates at 255;
  - streak clears to 0 on each miss_pulse;
  - updates in the same cycle the pulse asserts.
- Undefined: streak is tied to 0 and no counter logic is built.

Test Plan:
- Spawn one note, apply 100 frame_ticks → rd_idx=0 gives rd_valid=1, note_x=100, note_y=400, note_width=40; press → hit_pulse=1 one cycle, count=0, rd_valid=0.
- Spawn one note, apply 106 ticks without press → y=424 > 420, so miss_pulse=1 exactly once, rd_valid=0 afterwards.
- Press at y=376 (94 ticks) → miss_pulse=1, note retained; 2 more ticks (y=384), press → hit_pulse=1.
- Hold spawn_valid for 6 cycles → 4 accepted, spawn_ready=0 afterwards; rd_idx 0..3 all valid with y=0.
- Pop the head in the same cycle as spawning at full → refused; next cycle spawn_ready=1 and the spawn is accepted; rd order oldest-first preserved across pointer wrap.
- With NOTE_STREAK_EN: 3 hits → streak=3; 1 miss → 0; assert reset mid-stream → count=0, streak=0, no pulses.
